// File: rtl/wsg_pkg.sv
`default_nettype none
// ============================================================================
// wsg_pkg : shared constants for the WSG register sequencer
// Rev 1.0 : initial release
// ============================================================================
package wsg_pkg;

    localparam int unsigned c_NREG = 64;
    localparam logic [3:0]  c_NCH  = 4'd8;

    localparam logic [2:0] c_OFS_VOL = 3'd3;
    localparam logic [2:0] c_OFS_FL  = 3'd4;
    localparam logic [2:0] c_OFS_FM  = 3'd5;
    localparam logic [2:0] c_OFS_FH  = 3'd6;

    localparam logic [1:0] c_ST_INIT  = 2'd0;
    localparam logic [1:0] c_ST_SCAN  = 2'd1;
    localparam logic [1:0] c_ST_ISSUE = 2'd2;
    localparam logic [1:0] c_ST_GAP   = 2'd3;

    // True when a register at this channel offset must reach the WSG.
    function automatic logic wsg_fwd(input logic [2:0] ofs, input logic filter);
        return !filter || (ofs == c_OFS_VOL) || (ofs == c_OFS_FL) ||
               (ofs == c_OFS_FM) || (ofs == c_OFS_FH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wsg_shadow_ram.sv
`default_nettype none
// ============================================================================
// wsg_shadow_ram : 64x8 shadow RAM, one write port, registered CPU read port
//                  and an unregistered sequencer read port
// Rev 1.0 : initial release
// ============================================================================
module wsg_shadow_ram
    import wsg_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       wr_en_i,
    input  logic [5:0] wr_addr_i,
    input  logic [7:0] wr_data_i,
    input  logic [5:0] rd_addr_i,
    output logic [7:0] rd_data_o,
    input  logic [5:0] sq_addr_i,
    output logic [7:0] sq_data_o
);

    logic [7:0] mem_q [c_NREG];
    logic [7:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read-before-write: a same-cycle write returns the old contents.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;
    assign sq_data_o = mem_q[sq_addr_i];

endmodule
`default_nettype wire

// File: rtl/wsg_reg_seq.sv
`default_nettype none
// ============================================================================
// wsg_reg_seq : shadows CPU sound-register writes and replays dirty entries
//               to the WSG one strobe at a time with a programmable gap
// Rev 1.0 : initial release
// ============================================================================
module wsg_reg_seq
    import wsg_pkg::*;
#(
    parameter int unsigned WE_GAP = 3,
    parameter bit          FILTER = 1'b1
) (
    input  logic       CLK24M,
    input  logic       RST_N,
    input  logic [5:0] CPU_AD,
    input  logic [7:0] CPU_DI,
    input  logic       CPU_WE,
    output logic [7:0] CPU_DO,
    input  logic       FLUSH,
    output logic [5:0] ADDR,
    output logic [7:0] DATA,
    output logic       WE,
    output logic       PENDING
);

    localparam logic [3:0] c_GAP_LAST = (WE_GAP == 0) ? 4'd0 : 4'(WE_GAP - 1);

    logic [1:0]  state_q, state_d;
    logic [5:0]  ptr_q, ptr_d;
    logic [5:0]  addr_q, addr_d;
    logic [7:0]  data_q, data_d;
    logic [3:0]  gap_q, gap_d;
    logic [3:0]  init_q, init_d;
    logic [63:0] dirty_q, dirty_d;
    logic [63:0] fwd_mask, dirty_set, dirty_clr;
    logic [7:0]  sq_data;
    logic        leave;

    wsg_shadow_ram u_ram (
        .clk_i     (CLK24M),
        .rst_n_i   (RST_N),
        .wr_en_i   (CPU_WE),
        .wr_addr_i (CPU_AD),
        .wr_data_i (CPU_DI),
        .rd_addr_i (CPU_AD),
        .rd_data_o (CPU_DO),
        .sq_addr_i (ptr_q),
        .sq_data_o (sq_data)
    );

    always_comb begin
        fwd_mask = '0;
        for (int i = 0; i < c_NREG; i++) begin
            fwd_mask[i] = wsg_fwd(3'(i), FILTER);
        end
    end

    always_comb begin
        dirty_set = FLUSH ? fwd_mask : '0;
        if (CPU_WE && fwd_mask[CPU_AD]) begin
            dirty_set[CPU_AD] = 1'b1;
        end
    end

    always_ff @(posedge CLK24M or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= c_ST_INIT;
            ptr_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            gap_q   <= '0;
            init_q  <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            gap_q   <= gap_d;
            init_q  <= init_d;
            dirty_q <= dirty_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        addr_d    = addr_q;
        data_d    = data_q;
        gap_d     = gap_q;
        init_d    = init_q;
        dirty_clr = '0;
        leave     = 1'b0;
        case (state_q)
            c_ST_INIT: begin
                addr_d  = {3'd0, c_OFS_VOL};
                data_d  = '0;
                init_d  = 4'd1;
                state_d = c_ST_ISSUE;
            end
            c_ST_SCAN: begin
                if (dirty_q[ptr_q]) begin
                    addr_d           = ptr_q;
                    data_d           = sq_data;
                    dirty_clr[ptr_q] = 1'b1;
                    state_d          = c_ST_ISSUE;
                end else begin
                    ptr_d = ptr_q + 6'd1;
                end
            end
            c_ST_ISSUE: begin
                if (WE_GAP != 0) begin
                    gap_d   = c_GAP_LAST;
                    state_d = c_ST_GAP;
                end else begin
                    leave = 1'b1;
                end
            end
            default: begin
                if (gap_q == 4'd0) begin
                    leave = 1'b1;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
        endcase
        // The next INIT write is latched on the last gap cycle so strobes stay
        // exactly WE_GAP+1 cycles apart.
        if (leave) begin
            if (init_q != c_NCH) begin
                addr_d  = {init_q[2:0], c_OFS_VOL};
                data_d  = '0;
                init_d  = init_q + 4'd1;
                state_d = c_ST_ISSUE;
            end else begin
                ptr_d   = addr_q + 6'd1;
                state_d = c_ST_SCAN;
            end
        end
        dirty_d = (dirty_q & ~dirty_clr) | dirty_set;
    end

    always_comb begin
        WE      = (state_q == c_ST_ISSUE);
        PENDING = (|dirty_q) || (state_q != c_ST_SCAN);
        ADDR    = addr_q;
        DATA    = data_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_wsg_reg_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_wsg_reg_seq : directed and randomized checks against a behavioural model
// Rev 1.0 : initial release
// ============================================================================
module tb_wsg_reg_seq;

    localparam int G     = 3;
    localparam int WORST = 64 + 64 * (G + 1);

    logic       CLK24M = 1'b0;
    logic       RST_N  = 1'b0;
    logic [5:0] CPU_AD = '0;
    logic [7:0] CPU_DI = '0;
    logic       CPU_WE = 1'b0;
    logic       FLUSH  = 1'b0;
    logic [7:0] CPU_DO;
    logic [5:0] ADDR;
    logic [7:0] DATA;
    logic       WE;
    logic       PENDING;

    wsg_reg_seq #(.WE_GAP(G), .FILTER(1'b1)) dut (
        .CLK24M  (CLK24M),
        .RST_N   (RST_N),
        .CPU_AD  (CPU_AD),
        .CPU_DI  (CPU_DI),
        .CPU_WE  (CPU_WE),
        .CPU_DO  (CPU_DO),
        .FLUSH   (FLUSH),
        .ADDR    (ADDR),
        .DATA    (DATA),
        .WE      (WE),
        .PENDING (PENDING)
    );

    initial forever #5 CLK24M = ~CLK24M;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         we_cnt = 0;
    logic [7:0] m_ram [64];
    bit         m_val [64];
    logic [7:0] wsg_last [64];
    logic [7:0] exp_do = '0;
    bit         do_chk = 1'b0;
    bit         we_seen = 1'b0;
    logic [5:0] we_a = '0;
    logic [7:0] we_d = '0;

    function automatic bit fwd(input logic [5:0] a);
        return (a[2:0] >= 3'd3) && (a[2:0] <= 3'd6);
    endfunction

    function automatic logic [5:0] next_fwd(input logic [5:0] a);
        logic [5:0] n;
        n = a + 6'd1;
        while (!fwd(n)) n = n + 6'd1;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Observe the current cycle at the falling edge, then drive this cycle's inputs.
    task automatic tick(input bit we, input logic [5:0] ad, input logic [7:0] di, input bit fl);
        @(negedge CLK24M);
        cyc++;
        we_seen = WE;
        if (!RST_N) begin
            chk("we_in_reset", WE, 0);
        end else begin
            if (do_chk) chk("cpu_do", CPU_DO, exp_do);
            if (WE) begin
                we_cnt++;
                we_a = ADDR;
                we_d = DATA;
                wsg_last[ADDR] = DATA;
                chk("we_filtered", fwd(ADDR), 1);
            end
        end
        CPU_WE = we; CPU_AD = ad; CPU_DI = di; FLUSH = fl;
        exp_do = m_ram[ad];
        do_chk = m_val[ad] && RST_N;
        if (we) begin
            m_ram[ad] = di;
            m_val[ad] = 1'b1;
        end
    endtask

    task automatic idle();
        tick(1'b0, 6'($urandom_range(0, 63)), 8'h00, 1'b0);
    endtask

    task automatic wait_we(input int bound, output int c, output logic [5:0] a, output logic [7:0] d);
        c = -1; a = '0; d = '0;
        for (int i = 0; i < bound; i++) begin
            idle();
            if (we_seen) begin
                c = cyc; a = we_a; d = we_d;
                break;
            end
        end
        if (c < 0) chk("we_timeout", 0, 1);
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound; i++) begin
            idle();
            if (!PENDING) break;
        end
        chk("pending_drop", PENDING, 0);
    endtask

    // Collect the 8 INIT strobes; the first one has already been observed at c0.
    task automatic check_init_rest(input int c0);
        int c, prev;
        logic [5:0] a;
        logic [7:0] d;
        prev = c0;
        for (int ch = 1; ch < 8; ch++) begin
            wait_we(2 * (G + 2), c, a, d);
            chk("init_addr", a, {3'(ch), 3'd3});
            chk("init_data", d, 0);
            chk("init_space", c - prev, G + 1);
            prev = c;
        end
    endtask

    task automatic check_flush32();
        int c, n0;
        logic [5:0] a, prev;
        logic [7:0] d;
        n0 = we_cnt;
        prev = '0;
        for (int k = 0; k < 32; k++) begin
            wait_we(WORST, c, a, d);
            chk("flush_data", d, m_ram[a]);
            if (k > 0) chk("flush_order", a, next_fwd(prev));
            prev = a;
        end
        wait_idle(WORST);
        chk("flush_cnt", we_cnt - n0, 32);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c, r, w, n0;
        logic [5:0] a;
        logic [7:0] d;
        bit rw, rf;
        logic [5:0] rad;

        // Reset state
        repeat (3) idle();
        chk("rst_we", WE, 0);
        chk("rst_addr", ADDR, 0);
        chk("rst_data", DATA, 0);
        chk("rst_cpu_do", CPU_DO, 0);
        chk("rst_pending", PENDING, 1);

        // INIT sequence after release
        RST_N = 1'b1;
        r = cyc;
        wait_we(4, c, a, d);
        chk("init_first_lat", (c - r) <= 2, 1);
        chk("init_addr0", a, 6'h03);
        chk("init_data0", d, 0);
        check_init_rest(c);
        n0 = we_cnt;
        wait_idle(G + 3);
        chk("init_extra_we", we_cnt - n0, 0);

        // Overwrite before issue -> one strobe with the newest data
        n0 = we_cnt;
        tick(1'b1, 6'h0C, 8'h5A, 1'b0);
        tick(1'b1, 6'h0C, 8'hA5, 1'b0);
        wait_we(WORST, c, a, d);
        chk("ovw_addr", a, 6'h0C);
        chk("ovw_data", d, 8'hA5);
        wait_idle(WORST);
        chk("ovw_cnt", we_cnt - n0, 1);

        // Filtered offsets are never forwarded but read back
        n0 = we_cnt;
        tick(1'b1, 6'h00, 8'h11, 1'b0);
        tick(1'b1, 6'h07, 8'h77, 1'b0);
        tick(1'b0, 6'h00, 8'h00, 1'b0);
        tick(1'b0, 6'h07, 8'h00, 1'b0);
        chk("rb_00", CPU_DO, 8'h11);
        idle();
        chk("rb_07", CPU_DO, 8'h77);
        repeat (70) idle();
        chk("filt_we_cnt", we_cnt - n0, 0);

        // Minimum latency: pointer resumes at issued address + 1
        tick(1'b1, 6'h13, 8'h42, 1'b0);
        wait_we(WORST, w, a, d);
        chk("lat_anchor_addr", a, 6'h13);
        chk("lat_anchor_data", d, 8'h42);
        repeat (G - 1) idle();
        tick(1'b1, 6'h14, 8'h99, 1'b0);
        r = cyc;
        wait_we(4, c, a, d);
        chk("min_lat", c - r, 2);
        chk("min_lat_addr", a, 6'h14);
        chk("min_lat_data", d, 8'h99);
        wait_idle(WORST);

        // Write racing the scan clear -> old value now, new value later
        tick(1'b1, 6'h03, 8'h21, 1'b0);
        wait_we(WORST, w, a, d);
        chk("race_anchor", a, 6'h03);
        tick(1'b1, 6'h05, 8'h31, 1'b0);
        repeat (G) idle();
        tick(1'b1, 6'h05, 8'h32, 1'b0);
        wait_we(4, c, a, d);
        chk("race_addr1", a, 6'h05);
        chk("race_data1", d, 8'h31);
        wait_we(WORST, c, a, d);
        chk("race_addr2", a, 6'h05);
        chk("race_data2", d, 8'h32);
        wait_idle(WORST);

        // Load all registers, drain, then FLUSH
        for (int i = 0; i < 64; i++) tick(1'b1, 6'(i), 8'($urandom), 1'b0);
        wait_idle(WORST + 70);
        tick(1'b0, 6'h00, 8'h00, 1'b1);
        check_flush32();

        // Reset mid-GAP, FLUSH during INIT
        tick(1'b1, 6'h1D, 8'h5C, 1'b0);
        wait_we(WORST, w, a, d);
        idle();
        RST_N = 1'b0;
        repeat (3) idle();
        chk("rst2_pending", PENDING, 1);
        chk("rst2_addr", ADDR, 0);
        RST_N = 1'b1;
        tick(1'b0, 6'h00, 8'h00, 1'b1);
        chk("rst2_restart_we", we_seen, 1);
        chk("rst2_restart_addr", we_a, 6'h03);
        check_init_rest(cyc);
        check_flush32();

        // Randomized traffic, then every forwarded register must hold the model value
        for (int i = 0; i < 800; i++) begin
            rw  = ($urandom_range(0, 2) == 0);
            rad = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(8, 15)) : 6'($urandom);
            rf  = ($urandom_range(0, 149) == 0);
            tick(rw, rad, 8'($urandom), rf);
        end
        wait_idle(WORST + 20);
        for (int i = 0; i < 64; i++) begin
            if (fwd(6'(i)) && m_val[i]) chk("rand_final", wsg_last[i], m_ram[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
